// File: rtl/sd_spi_pkg.sv
// Shared types, constants and the serial CRC7 step for the SD SPI frontend.
// Purely combinational helpers; no state, no flow control.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_CMD  = 2'd1,
    ST_HOLD = 2'd2
  } framer_state_t;

  localparam int         CMD_BITS      = 48;
  localparam logic [6:0] CRC7_POLY     = 7'h09;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  // One bit of x^7+x^3+1, MSB-first, as the SD card computes it on the wire.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb        = crc[6] ^ din;
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_resp_fifo.sv
// Response byte FIFO, power-of-two depth, registered occupancy.
// Latency: a push is visible to pop one cycle later; pop data is read-combinational.
// Backpressure: full drops push_vld; flush wins over same-cycle push and pop.
module sd_spi_resp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign pop_dat = mem[rd_ptr];
  assign do_push = push_vld && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sd_spi_frontend.sv
// SD-card SPI slave frontend: oversampled bus, bit-serial command framer, MISO response shifter.
// Latency: SYNC_STAGES+1 sys_clk from an SCK edge to its effect on framer or MISO.
// Backpressure: cmd held until cmd_ready (later starts dropped); resp_ready low while FIFO full.
module sd_spi_frontend
  import sd_spi_pkg::*;
#(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int RESP_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          spi_sck,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic                          spi_miso_oe,
  output logic [CMD_BITS-1:0]           cmd_out,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_crc_good,
  input  logic [7:0]                    resp_data,
  input  logic                          resp_valid,
  output logic                          resp_ready,
  output logic [$clog2(RESP_DEPTH):0]   resp_level,
  output logic                          err_cmd_drop
);

  localparam logic       SCK_IDLE    = (CPOL != 0);
  localparam logic       SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
  localparam logic       LOAD_ON_CS  = (CPHA == 0);
  localparam logic [5:0] LAST_BIT    = 6'(CMD_BITS - 1);
  localparam logic [5:0] CRC_BITS    = 6'(CMD_BITS - 8);
  localparam logic [5:0] DROP_BITS   = 6'(CMD_BITS - 2);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sample_vld;
  logic                   shift_vld;
  logic                   cs_fall;
  logic                   cs_rise;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '1;
      sck_d     <= SCK_IDLE;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign cs_fall    = !cs_s && cs_d;
  assign cs_rise    = cs_s && !cs_d;
  assign sample_vld = !cs_s && (SAMPLE_RISE ? (sck_s && !sck_d) : (!sck_s && sck_d));
  assign shift_vld  = !cs_s && (SAMPLE_RISE ? (!sck_s && sck_d) : (sck_s && !sck_d));

  framer_state_t          state;
  framer_state_t          state_nxt;
  logic                   hunt_prev;
  logic                   hunt_hit;
  logic [5:0]             skip_cnt;
  logic [5:0]             bit_cnt;
  logic [CMD_BITS-2:0]    cmd_sr;
  logic [6:0]             crc;
  logic                   start_cmd;
  logic                   load_cmd;
  logic                   drop_start;

  // A start is a 0 followed by a 1; bits belonging to a dropped frame never qualify.
  assign hunt_hit  = sample_vld && (skip_cnt == '0) && !hunt_prev && mosi_s;
  assign cmd_valid = (state == ST_HOLD);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_cmd  = 1'b0;
    load_cmd   = 1'b0;
    drop_start = 1'b0;
    case (state)
      ST_HUNT: begin
        if (hunt_hit) begin
          state_nxt = ST_CMD;
          start_cmd = 1'b1;
        end
      end
      ST_CMD: begin
        if (sample_vld && (bit_cnt == LAST_BIT)) begin
          state_nxt = ST_HOLD;
          load_cmd  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cmd_ready) state_nxt = ST_HUNT;
        drop_start = hunt_hit;
      end
      default: state_nxt = ST_HUNT;
    endcase
    if (cs_s) begin
      state_nxt  = ST_HUNT;
      start_cmd  = 1'b0;
      load_cmd   = 1'b0;
      drop_start = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hunt_prev    <= 1'b1;
      skip_cnt     <= '0;
      bit_cnt      <= '0;
      cmd_sr       <= '0;
      crc          <= '0;
      cmd_out      <= '0;
      cmd_crc_good <= 1'b0;
      err_cmd_drop <= 1'b0;
    end else begin
      err_cmd_drop <= drop_start;
      if (cs_s) begin
        hunt_prev <= 1'b1;
        skip_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (sample_vld) begin
        hunt_prev <= (state == ST_CMD || start_cmd || drop_start || skip_cnt != '0) ? 1'b1 : mosi_s;
        if (drop_start)           skip_cnt <= DROP_BITS;
        else if (skip_cnt != '0)  skip_cnt <= skip_cnt - 6'd1;
        if (start_cmd) begin
          cmd_sr  <= {{(CMD_BITS-3){1'b0}}, 2'b01};
          bit_cnt <= 6'd2;
          crc     <= crc7_step(crc7_step(7'h00, 1'b0), 1'b1);
        end else if (state == ST_CMD) begin
          cmd_sr  <= {cmd_sr[CMD_BITS-3:0], mosi_s};
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt < CRC_BITS) crc <= crc7_step(crc, mosi_s);
        end
        if (load_cmd) begin
          cmd_out      <= {cmd_sr, mosi_s};
          cmd_crc_good <= mosi_s && (crc == cmd_sr[6:0]);
        end
      end
    end
  end

  logic       fifo_pop;
  logic [7:0] fifo_dat;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] next_byte;
  logic [7:0] tx_sr;
  logic [2:0] tx_bit;
  logic       tx_pend;
  logic       tx_load;

  sd_spi_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (8)
  ) u_resp_fifo (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .flush    (cs_rise),
    .push_vld (resp_valid),
    .push_dat (resp_data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (resp_level)
  );

  assign resp_ready  = !fifo_full;
  assign next_byte   = fifo_empty ? SPI_IDLE_BYTE : fifo_dat;
  assign fifo_pop    = tx_load;
  assign spi_miso    = tx_sr[7];
  assign spi_miso_oe = !cs_s;

  // CPHA=1 defers the first load to the first shift edge via tx_pend.
  always_comb begin
    tx_load = 1'b0;
    if (cs_rise)        tx_load = 1'b0;
    else if (cs_fall)   tx_load = LOAD_ON_CS;
    else if (shift_vld) tx_load = tx_pend || (tx_bit == 3'd0);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_sr   <= SPI_IDLE_BYTE;
      tx_bit  <= 3'd7;
      tx_pend <= 1'b0;
    end else if (cs_rise) begin
      tx_sr   <= SPI_IDLE_BYTE;
      tx_bit  <= 3'd7;
      tx_pend <= 1'b0;
    end else if (cs_fall) begin
      tx_bit  <= 3'd7;
      tx_pend <= !LOAD_ON_CS;
      if (LOAD_ON_CS) tx_sr <= next_byte;
    end else if (shift_vld) begin
      if (tx_load) begin
        tx_sr   <= next_byte;
        tx_bit  <= 3'd7;
        tx_pend <= 1'b0;
      end else begin
        tx_sr  <= {tx_sr[6:0], 1'b1};
        tx_bit <= tx_bit - 3'd1;
      end
    end
  end

endmodule
